// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame
//
// Purpose
//   UART transmit framer. A parallel payload is accepted on a valid strobe
//   while the framer is idle and is shifted out on TX_OUT one bit per clock:
//   start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit,
//   then a stop bit (1). The clock is already the bit clock; any baud rate
//   division happens upstream.
//
// Ports
//   clk         in   1           bit clock, rising-edge active
//   reset       in   1           asynchronous reset, active-low
//   P_DATA      in   DATA_WIDTH  payload, sampled only on the accepting edge
//   Data_Valid  in   1           request; accepted when high while busy is low
//   PAR_EN      in   1           1 = append a parity bit (sampled on accept)
//   PAR_TYP     in   1           0 = even, 1 = odd parity (sampled on accept)
//   TX_OUT      out  1           serial line, flop output, idles high
//   busy        out  1           flop output, high from start bit to stop bit
// ----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  // A one-bit payload still needs a one-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    tx_q;
  logic                    busy_q;

  logic [CNT_W-1:0]        cnt_inc;

  // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  odd);
    return (^d) ^ odd;
  endfunction

  assign cnt_inc = cnt_q + 1'b1;

  // Every output flop is loaded with the value belonging to the state being
  // entered, so TX_OUT/busy change exactly on the edge that changes state and
  // never depend combinationally on the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (Data_Valid) begin
            // Everything the frame needs is captured here, so later input
            // changes cannot disturb the frame in flight.
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= parity_bit(P_DATA, PAR_TYP);
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          tx_q    <= data_q[0];
        end

        DATA: begin
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            // Look one bit ahead: the flop shows data[cnt] while in DATA.
            cnt_q <= cnt_inc;
            tx_q  <= data_q[cnt_inc];
          end
        end

        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end

        STOP: begin
          // Requests are not looked at here, which guarantees one idle-high
          // cycle between back-to-back frames.
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
